vc_pop_scheduler: RTL
=====================

// Module: vc_pop_scheduler
// PURPOSE
//   Sequences all pops of the PCIe transaction datapath: main FIFO -> VC0/VC1, then VC0/VC1 -> mux -> D0/D1.
//   Arbitration between VCs is VC0-priority with a starvation guard: VC1 gets a forced grant after WEIGHT consecutive VC0 grants.
//   Pops are halted while the control FSM is not active, and halt permanently on error until reset.
//   Sits between the FIFO status flags and the FIFO pop inputs, beside the control FSM.
// PARAMETERS
//   WEIGHT  4  consecutive VC0 grants allowed while VC1 is non-empty before one forced VC1 grant (1..2**CNT_W-1)
//   CNT_W   3  width of the starvation counter
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   reset       in   1  asynchronous, active-high reset
//   enable      in   1  high while control FSM is in ACTIVE
//   error_in    in   1  OR of all FIFO error flags
//   mf_empty    in   1  main FIFO empty
//   mf_aempty   in   1  main FIFO occupancy <= 1
//   vc0_empty   in   1  VC0 FIFO empty
//   vc0_aempty  in   1  VC0 occupancy <= 1
//   vc1_empty   in   1  VC1 FIFO empty
//   vc1_aempty  in   1  VC1 occupancy <= 1
//   vc0_pause   in   1  VC0 pause (threshold reached)
//   vc1_pause   in   1  VC1 pause
//   d0_pause    in   1  D0 pause
//   d1_pause    in   1  D1 pause
//   pop_mf      out  1  pop main FIFO
//   pop_vc0     out  1  pop VC0 (one-hot with pop_vc1)
//   pop_vc1     out  1  pop VC1
//   halted      out  1  state is HALT or ERROR
//   sched_err   out  1  sticky error indication
// BEHAVIOUR
//   Reset: all outputs 0 except halted=1; state HALT; cnt=0; last_mf=last_vc0=last_vc1=0.
//   Outputs are registered; inputs sampled at edge N drive pops during cycle N+1 (latency 1).
//   States:
//     HALT:   enable=1 -> RUN.
//     RUN:    enable=0 -> HALT; error_in -> ERROR; d0_pause|d1_pause -> PAUSED.
//     PAUSED: both D pauses low -> RUN; enable=0 -> HALT; error_in -> ERROR.
//     ERROR:  exits only on reset. Priority: error_in > enable=0 > pause.
//   In HALT and ERROR all pops are 0. In PAUSED pop_vc0 = pop_vc1 = 0, but pop_mf still follows its rule.
//   Back-to-back guard: a FIFO popped in the previous cycle may be popped again only if its aempty is low.
//   Without the guard, a 1-entry FIFO would be double-popped because of the 1-cycle flag latency.
//   pop_mf = RUN|PAUSED & !mf_empty & !vc0_pause & !vc1_pause & !(last_mf & mf_aempty).
//   VC eligibility: eligX = !vcX_empty & !(last_vcX & vcX_aempty).
//   VC grant in RUN: if elig1 & (cnt==WEIGHT | !elig0) -> pop_vc1; else if elig0 -> pop_vc0; else none.
//   Counter:
//     increments on a VC0 grant while vc1_empty=0, saturating at WEIGHT;
//     clears on a VC1 grant or when vc1_empty=1;
//     holds in PAUSED/HALT.
//   sched_err = 1 from entry into ERROR until reset.
//   Asserting reset mid-transfer drops every pop in the same cycle (async); no partial state is kept.
// STRUCTURE
//   Shared package/header: state encodings (HALT, RUN, PAUSED, ERROR), default WEIGHT.
//   One sub-module: vc_arbiter (combinational eligibility + grant + starvation counter).
//   Top level holds the FSM, last_* registers and output registers.
// TESTING
//   1. Reset=1 then 0, enable=0, all FIFOs non-empty -> all pops 0 and halted=1 indefinitely.
//   2. enable=1, VC0 holds 3 entries, VC1 empty -> pop_vc0 high for 2 cycles.
//      On the 3rd cycle aempty is high with last_vc0 set, so the pop is skipped; a 3rd pop follows; total exactly 3 pops.
//   3. WEIGHT=4, both VCs hold 10 entries -> grant pattern VC0 x4, VC1 x1, repeating; never both high.
//   4. d1_pause=1 in RUN -> within 1 cycle pop_vc0 = pop_vc1 = 0 while pop_mf continues.
//      d1_pause=0 -> VC pops resume next cycle, counter value preserved.
//   5. error_in pulse of 1 cycle, then enable stays 1 -> ERROR, sched_err=1, pops 0 until reset.
//   6. reset asserted mid-stream between clock edges -> pops drop to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/vc_pop_scheduler_pkg.sv
// Shared definitions for the PCIe datapath pop scheduler: FSM state encoding and the default
// starvation-guard sizing.
package vc_pop_scheduler_pkg;

    typedef enum logic [1:0] {
        StHalt   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StError  = 2'd3
    } sched_state_e;

    localparam int unsigned DefaultWeight = 4;
    localparam int unsigned DefaultCntW   = 3;

endpackage

// File: rtl/vc_pop_scheduler_vc_arbiter.sv
// VC0-priority arbiter between the two virtual-channel FIFOs, with a starvation counter that
// forces one VC1 grant after WEIGHT consecutive VC0 grants while VC1 has data.
module vc_pop_scheduler_vc_arbiter
    import vc_pop_scheduler_pkg::*;
#(
    parameter int unsigned WEIGHT = DefaultWeight,
    parameter int unsigned CNT_W  = DefaultCntW
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_vc0_empty,
    input  logic i_vc0_aempty,
    input  logic i_vc1_empty,
    input  logic i_vc1_aempty,
    input  logic i_last_vc0,
    input  logic i_last_vc1,
    output logic o_grant_vc0,
    output logic o_grant_vc1
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WEIGHT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_elig0;
    logic             w_elig1;

    // A FIFO popped last cycle may still report the pre-pop occupancy, so a nearly-empty one
    // must sit out one cycle to avoid a double pop.
    assign w_elig0 = ~i_vc0_empty & ~(i_last_vc0 & i_vc0_aempty);
    assign w_elig1 = ~i_vc1_empty & ~(i_last_vc1 & i_vc1_aempty);

    always_comb begin
        o_grant_vc0 = 1'b0;
        o_grant_vc1 = 1'b0;
        w_cnt_d     = r_cnt;
        if (i_run) begin
            if (w_elig1 && ((r_cnt == CntMax) || !w_elig0)) begin
                o_grant_vc1 = 1'b1;
            end else if (w_elig0) begin
                o_grant_vc0 = 1'b1;
            end
            if (o_grant_vc1 || i_vc1_empty) begin
                w_cnt_d = '0;
            end else if (o_grant_vc0 && (r_cnt != CntMax)) begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Pop sequencer for the PCIe transaction datapath: main FIFO into the VC FIFOs, VC FIFOs into
// the output mux. Holds the run/pause/halt/error FSM and the registered pop outputs.
module vc_pop_scheduler
    import vc_pop_scheduler_pkg::*;
#(
    parameter int unsigned WEIGHT = DefaultWeight,
    parameter int unsigned CNT_W  = DefaultCntW
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_error_in,
    input  logic i_mf_empty,
    input  logic i_mf_aempty,
    input  logic i_vc0_empty,
    input  logic i_vc0_aempty,
    input  logic i_vc1_empty,
    input  logic i_vc1_aempty,
    input  logic i_vc0_pause,
    input  logic i_vc1_pause,
    input  logic i_d0_pause,
    input  logic i_d1_pause,
    output logic o_pop_mf,
    output logic o_pop_vc0,
    output logic o_pop_vc1,
    output logic o_halted,
    output logic o_sched_err
);

    sched_state_e r_state;
    sched_state_e w_state_d;
    logic         r_pop_mf;
    logic         r_pop_vc0;
    logic         r_pop_vc1;
    logic         r_halted;
    logic         r_sched_err;
    logic         w_active;
    logic         w_pop_mf;
    logic         w_grant_vc0;
    logic         w_grant_vc1;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StHalt: begin
                if (i_enable) w_state_d = StRun;
            end
            StRun: begin
                if (i_error_in)                    w_state_d = StError;
                else if (!i_enable)                w_state_d = StHalt;
                else if (i_d0_pause || i_d1_pause) w_state_d = StPaused;
            end
            StPaused: begin
                if (i_error_in)                        w_state_d = StError;
                else if (!i_enable)                    w_state_d = StHalt;
                else if (!i_d0_pause && !i_d1_pause) w_state_d = StRun;
            end
            StError: w_state_d = StError;
            default: w_state_d = StHalt;
        endcase
    end

    // Pops are decided from the state being entered, so a pause or error sampled at an edge
    // already suppresses the pops of the following cycle.
    assign w_active = (w_state_d == StRun) || (w_state_d == StPaused);
    assign w_pop_mf = w_active & ~i_mf_empty & ~i_vc0_pause & ~i_vc1_pause
                    & ~(r_pop_mf & i_mf_aempty);

    vc_pop_scheduler_vc_arbiter #(
        .WEIGHT (WEIGHT),
        .CNT_W  (CNT_W)
    ) u_vc_arbiter (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_run        (w_state_d == StRun),
        .i_vc0_empty  (i_vc0_empty),
        .i_vc0_aempty (i_vc0_aempty),
        .i_vc1_empty  (i_vc1_empty),
        .i_vc1_aempty (i_vc1_aempty),
        .i_last_vc0   (r_pop_vc0),
        .i_last_vc1   (r_pop_vc1),
        .o_grant_vc0  (w_grant_vc0),
        .o_grant_vc1  (w_grant_vc1)
    );

    // The registered pops double as the last_* history used by the back-to-back guard.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StHalt;
            r_pop_mf    <= 1'b0;
            r_pop_vc0   <= 1'b0;
            r_pop_vc1   <= 1'b0;
            r_halted    <= 1'b1;
            r_sched_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_pop_mf    <= w_pop_mf;
            r_pop_vc0   <= w_grant_vc0;
            r_pop_vc1   <= w_grant_vc1;
            r_halted    <= (w_state_d == StHalt) || (w_state_d == StError);
            r_sched_err <= (w_state_d == StError);
        end
    end

    assign o_pop_mf    = r_pop_mf;
    assign o_pop_vc0   = r_pop_vc0;
    assign o_pop_vc1   = r_pop_vc1;
    assign o_halted    = r_halted;
    assign o_sched_err = r_sched_err;

endmodule
